// File: rtl/value_fmt_pkg.sv
// value_fmt_pkg: mode codes, FSM encoding and digit-count helpers
// shared by the value formatter and its BCD converter.
package value_fmt_pkg;

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_HEX  = 2'd1;
  localparam logic [1:0] MODE_UDEC = 2'd2;
  localparam logic [1:0] MODE_SDEC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  // Decimal digits of 2^w-1: floor(w*log10(2))+1. The 5-digit
  // log10(2) approximation is exact for every w in 1..128.
  function automatic int dec_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

  function automatic int hex_digits(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one shift-add-3 step per cycle.
// Ports: clk_i, rst_i (async high), start_i loads bin_i, bcd_o result,
// done_o high during the cycle whose closing edge performs the last step.
module bin2bcd_seq
  import value_fmt_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEC_DIGITS = dec_digits(WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [WIDTH-1:0]        bin_i,
  output logic [4*DEC_DIGITS-1:0] bcd_o,
  output logic                    done_o
);

  localparam int BW = 4 * DEC_DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DEC_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sh_d  = bin_i;
      bcd_d = '0;
      cnt_d = STEPS;
    end else if (cnt_q != '0) begin
      bcd_d = {adj[BW-2:0], sh_q[WIDTH-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/value_fmt.sv
// value_fmt: formats a WIDTH-bit value as a stream of ASCII characters
// (binary, hex, unsigned or signed decimal) over a valid/ready handshake.
// Ports: i_clk, i_rst (async high), i_valid/i_value/i_mode/o_ready request,
// o_char/o_valid/o_last/i_ready character stream, o_busy.
module value_fmt
  import value_fmt_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEC_DIGITS = dec_digits(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_value,
  input  logic [1:0]       i_mode,
  output logic             o_ready,
  output logic [7:0]       o_char,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready,
  output logic             o_busy
);

  localparam int HEX = hex_digits(WIDTH);
  localparam int HW  = 4 * HEX;
  localparam int BW  = 4 * DEC_DIGITS;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             neg_q, neg_d;
  logic [7:0]       pos_q, pos_d;

  logic             neg_in;
  logic [WIDTH-1:0] mag;
  logic             cv_start, cv_done;
  logic [BW-1:0]    bcd;
  logic [HW-1:0]    vx;
  logic             is_last;
  logic [7:0]       ch;
  logic [3:0]       nib;
  int               n_chars, msd, pi, bi, hi, dj;

  // Two's complement magnitude; the most-negative value maps to
  // 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign neg_in = (i_mode == MODE_SDEC) && i_value[WIDTH-1];
  assign mag    = neg_in ? (~i_value + WIDTH'(1)) : i_value;

  bin2bcd_seq #(
    .WIDTH      (WIDTH),
    .DEC_DIGITS (DEC_DIGITS)
  ) u_bcd (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .start_i (cv_start),
    .bin_i   (mag),
    .bcd_o   (bcd),
    .done_o  (cv_done)
  );

  always_comb begin
    case (mode_q)
      MODE_BIN:  n_chars = WIDTH;
      MODE_HEX:  n_chars = HEX;
      MODE_UDEC: n_chars = DEC_DIGITS;
      default:   n_chars = DEC_DIGITS + 1;
    endcase
  end

  assign is_last = (state_q == ST_EMIT) &&
                   (int'(pos_q) == n_chars - 1);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    value_d  = value_q;
    neg_d    = neg_q;
    pos_d    = pos_q;
    cv_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          mode_d  = i_mode;
          value_d = i_value;
          neg_d   = neg_in;
          pos_d   = '0;
          if (i_mode[1]) begin
            cv_start = 1'b1;
            state_d  = ST_CONVERT;
          end else begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_CONVERT: begin
        if (cv_done) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (i_ready) begin
          if (is_last) state_d = ST_IDLE;
          else         pos_d   = pos_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BIN;
      value_q <= '0;
      neg_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      value_q <= value_d;
      neg_q   <= neg_d;
      pos_q   <= pos_d;
    end
  end

  // Most significant nonzero decimal digit (0 when the value is 0).
  always_comb begin
    msd = 0;
    for (int k = 0; k < DEC_DIGITS; k++) begin
      if (bcd[4*k +: 4] != 4'd0) msd = k;
    end
  end

  assign vx = HW'(value_q);

  always_comb begin
    ch  = 8'h20;
    nib = 4'd0;
    pi  = int'(pos_q);
    bi  = WIDTH - 1 - pi;
    hi  = HEX - 1 - pi;
    dj  = (mode_q == MODE_SDEC) ? DEC_DIGITS - pi
                                : DEC_DIGITS - 1 - pi;
    case (mode_q)
      MODE_BIN: begin
        if (bi >= 0 && bi < WIDTH)
          ch = value_q[bi] ? 8'h31 : 8'h30;
      end
      MODE_HEX: begin
        if (hi >= 0 && hi < HEX) begin
          nib = vx[4*hi +: 4];
          ch  = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                              : (8'h57 + {4'h0, nib});
        end
      end
      default: begin
        // Digits up to the leading one; sign sits just left of it.
        if (dj >= 0 && dj <= msd)
          ch = 8'h30 | {4'h0, bcd[4*dj +: 4]};
        else if (neg_q && dj == msd + 1)
          ch = 8'h2d;
      end
    endcase
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_valid = (state_q == ST_EMIT);
  assign o_last  = is_last;
  assign o_char  = (state_q == ST_EMIT) ? ch : 8'h20;

endmodule

// File: tb/tb_value_fmt.sv
// tb_value_fmt: scoreboard bench for value_fmt at WIDTH=32 and WIDTH=65.
// Expected characters are queued on request and popped on each transfer.
module tb_value_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [64:0] val;
  logic [1:0]  mode;
  logic        rdy;
  logic        sel;

  logic       rd32, ov32, ol32, bz32;
  logic [7:0] ch32;
  logic       rd65, ov65, ol65, bz65;
  logic [7:0] ch65;

  logic       o_ready, o_valid, o_last, o_busy;
  logic [7:0] o_char;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  value_fmt #(.WIDTH(32)) dut32 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (vld && !sel),
    .i_value (val[31:0]),
    .i_mode  (mode),
    .o_ready (rd32),
    .o_char  (ch32),
    .o_valid (ov32),
    .o_last  (ol32),
    .i_ready (rdy),
    .o_busy  (bz32)
  );

  value_fmt #(.WIDTH(65)) dut65 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (vld && sel),
    .i_value (val),
    .i_mode  (mode),
    .o_ready (rd65),
    .o_char  (ch65),
    .o_valid (ov65),
    .o_last  (ol65),
    .i_ready (rdy),
    .o_busy  (bz65)
  );

  assign o_ready = sel ? rd65 : rd32;
  assign o_valid = sel ? ov65 : ov32;
  assign o_last  = sel ? ol65 : ol32;
  assign o_busy  = sel ? bz65 : bz32;
  assign o_char  = sel ? ch65 : ch32;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic send(input logic s, input logic [1:0] m,
                      input logic [64:0] v, input string e,
                      input int stall);
    int lat, w, g;
    logic [7:0] c, want;
    logic l, hv, r;
    sel = s;
    w = s ? 65 : 32;
    for (int i = 0; i < e.len(); i++) q.push_back(8'(e[i]));
    chk("ready_before", 64'(o_ready), 64'd1);
    mode = m;
    val  = v;
    vld  = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after accept; i_valid stays high while busy
    val  = 65'({$urandom, $urandom, $urandom});
    mode = 2'($urandom);
    lat  = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    vld = 1'b0;
    chk("latency", 64'(lat), 64'((m >= 2'd2) ? w + 1 : 1));
    chk("busy", 64'(o_busy), 64'd1);
    g = 0;
    while (q.size() > 0 && g < 3000) begin
      r  = (stall == 0) || ($urandom_range(99) >= stall);
      rdy = r;
      c  = o_char;
      l  = o_last;
      hv = o_valid;
      @(posedge clk); #1;
      g++;
      chk("valid_in_emit", 64'(hv), 64'd1);
      if (r) begin
        want = q.pop_front();
        chk("char", 64'(c), 64'(want));
        chk("last", 64'(l), 64'(q.size() == 0));
      end else begin
        chk("hold_char", 64'(o_char), 64'(c));
        chk("hold_last", 64'(o_last), 64'(l));
        chk("hold_valid", 64'(o_valid), 64'(hv));
      end
    end
    rdy = 1'b0;
    chk("drained", 64'(q.size()), 64'd0);
    q.delete();
    chk("ready_after", 64'(o_ready), 64'd1);
    chk("valid_after", 64'(o_valid), 64'd0);
  endtask

  initial begin
    string ones, e;
    logic [31:0] rv;
    int rm;
    logic seen;

    rst = 1'b1; vld = 1'b0; rdy = 1'b0; sel = 1'b0;
    val = '0; mode = 2'd0;
    #1;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_char", 64'(o_char), 64'h20);
    chk("rst_ready65", 64'(rd65), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(0, 2'd1, 65'hFFFFFFFF, "ffffffff", 0);
    send(0, 2'd2, 65'hFFFFFFFF, "4294967295", 0);
    send(0, 2'd2, 65'd5, "         5", 0);
    send(0, 2'd2, 65'd0, "         0", 20);
    send(0, 2'd3, 65'hFFFFFFFF, "         -1", 0);
    send(0, 2'd3, 65'h80000000, "-2147483648", 30);
    send(0, 2'd3, 65'h7FFFFFFF, " 2147483647", 0);
    send(0, 2'd0, 65'hA5A50F0F,
         "10100101101001010000111100001111", 30);
    send(0, 2'd1, 65'h00C0FFEE, "00c0ffee", 40);

    for (int k = 0; k < 8; k++) begin
      rv = $urandom;
      rm = $urandom_range(3);
      case (rm)
        0:       e = $sformatf("%032b", rv);
        1:       e = $sformatf("%08h", rv);
        2:       e = $sformatf("%10d", rv);
        default: e = $sformatf("%11d", $signed(rv));
      endcase
      send(0, 2'(rm), 65'(rv), e, 40);
    end

    // reset mid-EMIT of a hex request
    sel = 1'b0; mode = 2'd1; val = 65'h1234ABCD; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_char", 64'(o_char), 64'h20);
    @(posedge clk); #1;
    rst = 1'b0; rdy = 1'b0;
    send(0, 2'd1, 65'h0BADF00D, "0badf00d", 30);

    // reset mid-CONVERT abandons the request
    mode = 2'd2; val = 65'd12345; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1'b1;
    end
    chk("no_emit_after_rst", 64'(seen), 64'd0);
    rdy = 1'b0;

    ones = "";
    for (int k = 0; k < 65; k++) ones = {ones, "1"};
    send(1, 2'd0, {65{1'b1}}, ones, 25);
    send(1, 2'd2, {65{1'b1}}, "36893488147419103231", 25);
    send(1, 2'd1, {65{1'b1}}, "1ffffffffffffffff", 0);
    send(1, 2'd3, {1'b1, 64'd0}, "-18446744073709551616", 20);
    send(1, 2'd3, 65'd42, "                   42", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
